alu_sequencer: RTL and testbench

Issue-side controller for the 16-bit combinational ALU. It accepts 16-bit instruction words over a valid/ready handshake and decodes them. It reads operands from an internal 16x16 register file and drives the ALU's A, B and Opcode inputs from registers. It then captures the ALU result and writes it back to the destination register. It sits between instruction fetch and the ALU, and forms the datapath core of the processor.

---
 rtl/alu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Issue-side controller for a 16-bit combinational ALU. Accepts instruction
// words over a valid/ready handshake, reads operands from an internal
// register file, and presents registered operands and an opcode to the ALU.
// One cycle later it captures the ALU result and writes it back to the
// destination register. Execution is strictly serial: one instruction is in
// flight at a time, retiring every three cycles.
//
// Instruction format: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt, imm8=[7:0]
//   0000 ADD  rd = rs + rt
//   0001 SUB  rd = rs - rt
//   0010 SLL  rd = rs << rt
//   0011 AND  rd = rs & rt
//   0100 LI   rd = zero-extended imm8 (issued as ADD 0 + imm8)
//   others    illegal: retire with err, no write-back
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   instr_valid  instr holds a valid instruction
//   instr_ready  sequencer can accept an instruction (depends on state only)
//   instr        instruction word
//   alu_a        ALU operand A, registered
//   alu_b        ALU operand B, registered
//   alu_opcode   ALU opcode, registered
//   alu_result   combinational ALU result
//   done         one-cycle pulse: instruction retired
//   err          one-cycle pulse with done: illegal opcode
//   wb_data      value written back, valid while done=1 (0 for illegal ops)
//   retired_cnt  count of retired instructions, wraps at 0xFFFF
//   dbg_addr     debug register-file read address
//   dbg_data     rf[dbg_addr], combinational
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] wb_data,
  output logic [15:0]       retired_cnt,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_LI  = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rf [NREGS];
  logic [3:0]        rd_p0;
  logic              ill_p0;

  logic [3:0] f_op;
  logic [3:0] f_rd;
  logic [3:0] f_rs;
  logic [3:0] f_rt;
  logic [7:0] f_imm;

  assign f_op  = instr[15:12];
  assign f_rd  = instr[11:8];
  assign f_rs  = instr[7:4];
  assign f_rt  = instr[3:0];
  assign f_imm = instr[7:0];

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_AND, OP_LI: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] zext_imm(input logic [7:0] imm);
    zext_imm = {{(DATA_W-8){1'b0}}, imm};
  endfunction

  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      rd_p0       <= '0;
      ill_p0      <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      wb_data     <= '0;
      retired_cnt <= '0;
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      // done/err are single-cycle pulses; only the EXEC edge raises them
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        // Issue stage: sample instr, read operands, drive the ALU
        IDLE: begin
          if (instr_valid) begin
            rd_p0  <= f_rd;
            ill_p0 <= !is_legal(f_op);
            if (f_op == OP_LI) begin
              alu_a      <= '0;
              alu_b      <= zext_imm(f_imm);
              alu_opcode <= OP_ADD;
            end else begin
              alu_a      <= rf[f_rs];
              alu_b      <= rf[f_rt];
              alu_opcode <= f_op;
            end
            instr_ready <= 1'b0;
            state       <= EXEC;
          end
        end
        // Execute stage: ALU has settled, capture and retire
        EXEC: begin
          if (ill_p0) begin
            wb_data <= '0;
            err     <= 1'b1;
          end else begin
            rf[rd_p0] <= alu_result;
            wb_data   <= alu_result;
          end
          done        <= 1'b1;
          retired_cnt <= retired_cnt + 16'd1;
          state       <= WB;
        end
        // Write-back stage: done/err visible this cycle, then reopen
        WB: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Drives alu_sequencer with directed and randomized instruction streams. A
// combinational ALU model answers the DUT's operand outputs; an architectural
// register-file model predicts operands, write-back values and counters.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        done;
  logic        err;
  logic [15:0] wb_data;
  logic [15:0] retired_cnt;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(16), .NREGS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .done        (done),
    .err         (err),
    .wb_data     (wb_data),
    .retired_cnt (retired_cnt),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Combinational ALU; illegal opcodes produce a recognisable junk value
  always_comb begin
    alu_result = 16'hDEAD;
    case (alu_opcode)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a << alu_b;
      4'd3: alu_result = alu_a & alu_b;
      default: alu_result = 16'hDEAD;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_rf [16];
  logic [15:0] m_cnt;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [3:0]  m_opc;
  int          last_acc = 0;
  bit          chained  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
    m_cnt   = 16'h0;
    m_a     = 16'h0;
    m_b     = 16'h0;
    m_opc   = 4'h0;
    chained = 1'b0;
  endtask

  // Architectural result of one instruction given the current register file
  function automatic logic [15:0] arch_result(input logic [15:0] ins);
    logic [15:0] s;
    logic [15:0] t;
    logic [31:0] sh;
    s = m_rf[ins[7:4]];
    t = m_rf[ins[3:0]];
    case (ins[15:12])
      4'd0: arch_result = 16'((32'(s) + 32'(t)) % 32'h10000);
      4'd1: arch_result = 16'((32'h10000 + 32'(s) - 32'(t)) % 32'h10000);
      4'd2: begin
        sh = (t >= 16'd16) ? 32'h0 : (32'(s) * (32'h1 << t));
        arch_result = sh[15:0];
      end
      4'd3: arch_result = s & t;
      4'd4: arch_result = {8'h00, ins[7:0]};
      default: arch_result = 16'h0;
    endcase
  endfunction

  // Issue one instruction; valid stays high afterwards with junk on instr,
  // so consecutive calls form a back-to-back stream.
  task automatic send(input logic [15:0] ins, input logic [15:0] junk);
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] exp_wb;
    bit          legal;
    int          budget;
    op    = ins[15:12];
    rd    = ins[11:8];
    legal = (op <= 4'd4);
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    budget = 0;
    while (!instr_ready && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (!instr_ready) begin
      check_eq("ready_timeout", 32'(instr_ready), 32'h1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (chained) check_eq("throughput", 32'(cyc - last_acc), 32'd3);
    last_acc = cyc;
    if (op == 4'd4) begin
      m_a = 16'h0; m_b = {8'h00, ins[7:0]}; m_opc = 4'd0;
    end else begin
      m_a = m_rf[ins[7:4]]; m_b = m_rf[ins[3:0]]; m_opc = op;
    end
    check_eq("exec_alu_a", 32'(alu_a), 32'(m_a));
    check_eq("exec_alu_b", 32'(alu_b), 32'(m_b));
    check_eq("exec_opcode", 32'(alu_opcode), 32'(m_opc));
    check_eq("exec_ready", 32'(instr_ready), 32'h0);
    check_eq("exec_done", 32'(done), 32'h0);
    exp_wb = arch_result(ins);
    instr  = junk;
    @(posedge clk);
    #1;
    m_cnt = m_cnt + 16'd1;
    check_eq("wb_done", 32'(done), 32'h1);
    check_eq("wb_err", 32'(err), legal ? 32'h0 : 32'h1);
    check_eq("wb_data", 32'(wb_data), legal ? 32'(exp_wb) : 32'h0);
    check_eq("wb_ready", 32'(instr_ready), 32'h0);
    check_eq("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
    if (legal) m_rf[rd] = exp_wb;
    dbg_addr = rd;
    #1;
    check_eq("dbg_rd", 32'(dbg_data), 32'(m_rf[rd]));
    @(posedge clk);
    #1;
    check_eq("idle_done", 32'(done), 32'h0);
    check_eq("idle_err", 32'(err), 32'h0);
    check_eq("idle_ready", 32'(instr_ready), 32'h1);
    chained = 1'b1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_eq("hold_done", 32'(done), 32'h0);
      check_eq("hold_ready", 32'(instr_ready), 32'h1);
      check_eq("hold_alu_a", 32'(alu_a), 32'(m_a));
      check_eq("hold_alu_b", 32'(alu_b), 32'(m_b));
    end
    chained = 1'b0;
  endtask

  task automatic check_rf_clear();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check_eq("rst_dbg", 32'(dbg_data), 32'h0);
    end
  endtask

  // Asynchronous reset asserted away from any clock edge
  task automatic do_reset();
    @(negedge clk);
    instr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready", 32'(instr_ready), 32'h1);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_cnt", 32'(retired_cnt), 32'h0);
    check_eq("rst_alu_a", 32'(alu_a), 32'h0);
    check_eq("rst_wb", 32'(wb_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_rf_clear();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0;
    dbg_addr    = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("init_ready", 32'(instr_ready), 32'h1);
    check_eq("init_done", 32'(done), 32'h0);
    check_eq("init_opcode", 32'(alu_opcode), 32'h0);
    check_rf_clear();

    // LI then ADD
    send(16'h417F, 16'($urandom));
    send(16'h4205, 16'($urandom));
    send(16'h0312, 16'($urandom));
    idle(2);

    // Mid-run reset then idle checks
    do_reset();

    // Build r1 = 0xFFFF, then wrap/underflow/shift cases
    send(16'h41FF, 16'($urandom));
    send(16'h4708, 16'($urandom));
    send(16'h2117, 16'($urandom));
    send(16'h48FF, 16'($urandom));
    send(16'h0118, 16'($urandom));
    send(16'h0411, 16'($urandom));
    send(16'h4100, 16'($urandom));
    send(16'h4201, 16'($urandom));
    send(16'h1512, 16'($urandom));
    send(16'h470F, 16'($urandom));
    send(16'h2627, 16'($urandom));
    idle(1);

    // Illegal opcode leaves r1 untouched
    send(16'h4155, 16'($urandom));
    send(16'h9123, 16'($urandom));
    dbg_addr = 4'd1;
    #1;
    check_eq("illegal_r1", 32'(dbg_data), 32'h0055);

    // rd == rs
    send(16'h4103, 16'($urandom));
    send(16'h0111, 16'($urandom));
    idle(1);

    // Reset during EXEC of ADD r3
    do_reset();
    send(16'h4102, 16'($urandom));
    send(16'h4203, 16'($urandom));
    @(negedge clk);
    instr       = 16'h0312;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rexec_alu_a", 32'(alu_a), 32'h2);
    instr_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    check_eq("rexec_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) begin
      @(posedge clk);
      #1;
      check_eq("rexec_nodone", 32'(done), 32'h0);
      check_eq("rexec_ready", 32'(instr_ready), 32'h1);
    end
    dbg_addr = 4'd3;
    #1;
    check_eq("rexec_r3", 32'(dbg_data), 32'h0);
    check_eq("rexec_cnt", 32'(retired_cnt), 32'h0);

    // Randomized stream, mostly legal, with occasional idle gaps
    for (int k = 0; k < 200; k++) begin
      logic [3:0]  op;
      logic [15:0] ins;
      op  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
      ins = {op, 12'($urandom)};
      send(ins, 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
